// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage state encoding, CPSR flag bit positions
// and the default memory access timeout.
package cpu_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StMemWait
  } mem_state_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  localparam int unsigned MemTimeoutDefault = 16;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of EX handshake, data-memory bus and writeback/status signals of the MEM stage.
interface mem_stage_if;
  import cpu_pkg::*;

  logic        ex_valid;
  logic        ex_ready;
  logic [32:0] ex_result;
  logic [2:0]  ex_dest_reg;
  logic        ex_wb_en;
  logic        ex_flags_en;
  logic [3:0]  ex_flags_new;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [31:0] ex_store_data;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic [3:0]  flags;
  logic        mem_fault;

  modport slave (
    input  ex_valid, ex_result, ex_dest_reg, ex_wb_en, ex_flags_en, ex_flags_new,
    input  ex_is_load, ex_is_store, ex_store_data, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_en, wb_reg, wb_data, flags, mem_fault
  );

  modport master (
    output ex_valid, ex_result, ex_dest_reg, ex_wb_en, ex_flags_en, ex_flags_new,
    output ex_is_load, ex_is_store, ex_store_data, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_en, wb_reg, wb_data, flags, mem_fault
  );

endinterface

// File: rtl/cpsr_reg.sv
// CPSR flag register (N,C,Z,V) with load enable; cleared by reset.
module cpsr_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] flags_i,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (load_i) flags_d = flags_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers ALU writebacks, runs one data-memory access at a
// time with timeout, and flags misaligned/illegal/timed-out accesses in a sticky fault.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
) (
  input logic         clk,
  input logic         rst_n,
  mem_stage_if.slave  bus
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  mem_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            ld_wb_q, ld_wb_d;
  logic [2:0]      ld_reg_q, ld_reg_d;
  logic            wb_en_q, wb_en_d;
  logic [2:0]      wb_reg_q, wb_reg_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            fault_q, fault_d;
  logic            flags_load;
  logic            ex_ready;
  logic            transfer, is_mem, illegal, misaligned;
  logic            unused_result_msb;

  assign unused_result_msb = bus.ex_result[32];

  // ex_ready is gated by rst_n so it reads 0 while reset is held.
  assign ex_ready   = rst_n & (state_q == StIdle);
  assign transfer   = bus.ex_valid & ex_ready;
  assign is_mem     = bus.ex_is_load | bus.ex_is_store;
  assign illegal    = bus.ex_is_load & bus.ex_is_store;
  assign misaligned = is_mem & (|bus.ex_result[1:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_wb_d     = ld_wb_q;
    ld_reg_d    = ld_reg_q;
    wb_en_d     = 1'b0;
    wb_reg_d    = '0;
    wb_data_d   = '0;
    fault_d     = fault_q;
    flags_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          if (illegal || misaligned) begin
            fault_d = 1'b1;
          end else if (is_mem) begin
            state_d     = StMemWait;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.ex_is_store;
            mem_addr_d  = bus.ex_result[31:0];
            mem_wdata_d = bus.ex_store_data;
            ld_wb_d     = bus.ex_is_load & bus.ex_wb_en;
            ld_reg_d    = bus.ex_dest_reg;
          end else begin
            wb_en_d    = bus.ex_wb_en;
            flags_load = bus.ex_flags_en;
            if (bus.ex_wb_en) begin
              wb_reg_d  = bus.ex_dest_reg;
              wb_data_d = bus.ex_result[31:0];
            end
          end
        end
      end
      StMemWait: begin
        // Ack is checked first so it wins over a timeout on the same edge.
        if (bus.mem_ack || cnt_q == CntLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          ld_wb_d     = 1'b0;
          if (bus.mem_ack) begin
            wb_en_d = ld_wb_q;
            if (ld_wb_q) begin
              wb_reg_d  = ld_reg_q;
              wb_data_d = bus.mem_rdata;
            end
          end else begin
            fault_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_wb_q     <= 1'b0;
      ld_reg_q    <= '0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_wb_q     <= ld_wb_d;
      ld_reg_q    <= ld_reg_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      fault_q     <= fault_d;
    end
  end

  cpsr_reg u_cpsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (flags_load),
    .flags_i (bus.ex_flags_new),
    .flags_o (bus.flags)
  );

  assign bus.ex_ready  = ex_ready;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_req_q & mem_we_q;
  assign bus.mem_addr  = mem_req_q ? mem_addr_q  : '0;
  assign bus.mem_wdata = mem_req_q ? mem_wdata_q : '0;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.mem_fault = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU writeback, load/store, timeout, misalignment,
// illegal op and reset behaviour, each checked against hand-computed values.
module tb_mem_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mem_stage_if bus ();

  mem_stage #(
    .MEM_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [32:0] res,
                          input logic [2:0] dest, input logic wb, input logic fl_en,
                          input logic [3:0] fl, input logic [31:0] sdata);
    bus.ex_valid      = 1'b1;
    bus.ex_is_load    = ld;
    bus.ex_is_store   = st;
    bus.ex_result     = res;
    bus.ex_dest_reg   = dest;
    bus.ex_wb_en      = wb;
    bus.ex_flags_en   = fl_en;
    bus.ex_flags_new  = fl;
    bus.ex_store_data = sdata;
  endtask

  task automatic idle_ex();
    drive_op(1'b0, 1'b0, 33'h0, 3'd0, 1'b0, 1'b0, 4'h0, 32'h0);
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] nzcv;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_ex();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset state
    #2;
    check("rst_ex_ready", {31'h0, bus.ex_ready}, 32'h0);
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_wb_en", {31'h0, bus.wb_en}, 32'h0);
    check("rst_flags", {28'h0, bus.flags}, 32'h0);
    check("rst_fault", {31'h0, bus.mem_fault}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_ex_ready", {31'h0, bus.ex_ready}, 32'h1);

    // ALU op with writeback and flags, then a back-to-back op (bit 32 ignored)
    drive_op(1'b0, 1'b0, 33'h0_0000_0005, 3'd3, 1'b1, 1'b1, 4'b0010, 32'h0);
    step();
    check("alu_wb_en", {31'h0, bus.wb_en}, 32'h1);
    check("alu_wb_reg", {29'h0, bus.wb_reg}, 32'h3);
    check("alu_wb_data", bus.wb_data, 32'h5);
    check("alu_flags", {28'h0, bus.flags}, 32'h2);
    drive_op(1'b0, 1'b0, 33'h1_0000_0007, 3'd6, 1'b1, 1'b0, 4'b1111, 32'h0);
    step();
    check("b2b_wb_en", {31'h0, bus.wb_en}, 32'h1);
    check("b2b_wb_reg", {29'h0, bus.wb_reg}, 32'h6);
    check("b2b_wb_data", bus.wb_data, 32'h7);
    check("b2b_flags_held", {28'h0, bus.flags}, 32'h2);
    idle_ex();
    step();
    check("alu_wb_pulse_end", {31'h0, bus.wb_en}, 32'h0);

    // Load at 0x100, ack sampled on the third edge after mem_req rises
    drive_op(1'b1, 1'b0, 33'h100, 3'd2, 1'b1, 1'b1, 4'b1111, 32'h0);
    step();
    idle_ex();
    check("ld_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("ld_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("ld_mem_addr", bus.mem_addr, 32'h100);
    check("ld_ex_ready_wait", {31'h0, bus.ex_ready}, 32'h0);
    step();
    step();
    check("ld_ex_ready_wait2", {31'h0, bus.ex_ready}, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    check("ld_req_fall", {31'h0, bus.mem_req}, 32'h0);
    check("ld_addr_zero", bus.mem_addr, 32'h0);
    check("ld_wb_en", {31'h0, bus.wb_en}, 32'h1);
    check("ld_wb_reg", {29'h0, bus.wb_reg}, 32'h2);
    check("ld_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    check("ld_flags_ignored", {28'h0, bus.flags}, 32'h2);
    step();
    check("ld_wb_pulse_end", {31'h0, bus.wb_en}, 32'h0);

    // Store at 0x104 with wb_en requested (must be ignored)
    drive_op(1'b0, 1'b1, 33'h104, 3'd5, 1'b1, 1'b1, 4'b1000, 32'h1234_5678);
    step();
    idle_ex();
    check("st_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("st_mem_we", {31'h0, bus.mem_we}, 32'h1);
    check("st_mem_addr", bus.mem_addr, 32'h104);
    check("st_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("st_req_fall", {31'h0, bus.mem_req}, 32'h0);
    check("st_we_zero", {31'h0, bus.mem_we}, 32'h0);
    check("st_wdata_zero", bus.mem_wdata, 32'h0);
    check("st_no_wb", {31'h0, bus.wb_en}, 32'h0);
    check("st_flags_ignored", {28'h0, bus.flags}, 32'h2);

    // Ack on the same edge the timeout would fire: completes normally
    drive_op(1'b1, 1'b0, 33'h300, 3'd4, 1'b1, 1'b0, 4'h0, 32'h0);
    step();
    idle_ex();
    for (int i = 0; i < 15; i++) step();
    check("ackto_req_still", {31'h0, bus.mem_req}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    check("ackto_req_fall", {31'h0, bus.mem_req}, 32'h0);
    check("ackto_wb_en", {31'h0, bus.wb_en}, 32'h1);
    check("ackto_wb_data", bus.wb_data, 32'hCAFE_F00D);
    check("ackto_no_fault", {31'h0, bus.mem_fault}, 32'h0);
    step();

    // Misaligned load at 0x102
    drive_op(1'b1, 1'b0, 33'h102, 3'd1, 1'b1, 1'b0, 4'h0, 32'h0);
    step();
    idle_ex();
    check("mis_no_req", {31'h0, bus.mem_req}, 32'h0);
    check("mis_fault", {31'h0, bus.mem_fault}, 32'h1);
    check("mis_no_wb", {31'h0, bus.wb_en}, 32'h0);
    check("mis_ex_ready", {31'h0, bus.ex_ready}, 32'h1);
    step();
    step();
    check("mis_no_req_later", {31'h0, bus.mem_req}, 32'h0);
    check("fault_sticky", {31'h0, bus.mem_fault}, 32'h1);

    // Reset clears the sticky fault and flags
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_fault_clr", {31'h0, bus.mem_fault}, 32'h0);
    check("rst2_flags_clr", {28'h0, bus.flags}, 32'h0);
    step();

    // Flag-only ALU op: N and Z set via package indices
    nzcv = 4'b0000;
    nzcv[FlagN] = 1'b1;
    nzcv[FlagZ] = 1'b1;
    drive_op(1'b0, 1'b0, 33'h9, 3'd7, 1'b0, 1'b1, nzcv, 32'h0);
    step();
    idle_ex();
    check("flg_flags", {28'h0, bus.flags}, 32'hA);
    check("flg_no_wb", {31'h0, bus.wb_en}, 32'h0);

    // Load never acknowledged: times out after 16 cycles of mem_req
    drive_op(1'b1, 1'b0, 33'h200, 3'd1, 1'b1, 1'b0, 4'h0, 32'h0);
    step();
    idle_ex();
    for (int i = 0; i < 15; i++) step();
    check("to_req_cycle16", {31'h0, bus.mem_req}, 32'h1);
    check("to_no_fault_yet", {31'h0, bus.mem_fault}, 32'h0);
    step();
    check("to_req_fall", {31'h0, bus.mem_req}, 32'h0);
    check("to_fault", {31'h0, bus.mem_fault}, 32'h1);
    check("to_no_wb", {31'h0, bus.wb_en}, 32'h0);
    check("to_ex_ready", {31'h0, bus.ex_ready}, 32'h1);
    step();
    check("to_no_wb_later", {31'h0, bus.wb_en}, 32'h0);

    // Asynchronous reset while waiting on a load
    drive_op(1'b1, 1'b0, 33'h400, 3'd2, 1'b1, 1'b0, 4'h0, 32'h0);
    step();
    idle_ex();
    check("ar_req_before", {31'h0, bus.mem_req}, 32'h1);
    check("ar_flags_before", {28'h0, bus.flags}, 32'hA);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req_drop", {31'h0, bus.mem_req}, 32'h0);
    check("ar_flags_clr", {28'h0, bus.flags}, 32'h0);
    check("ar_ex_ready", {31'h0, bus.ex_ready}, 32'h0);
    check("ar_fault_clr", {31'h0, bus.mem_fault}, 32'h0);
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    rst_n = 1'b1;
    step();
    check("ar_no_wb", {31'h0, bus.wb_en}, 32'h0);
    check("ar_no_reissue", {31'h0, bus.mem_req}, 32'h0);
    step();
    check("ar_no_wb2", {31'h0, bus.wb_en}, 32'h0);

    // Illegal load+store: dropped with fault and no side effects
    drive_op(1'b1, 1'b1, 33'h500, 3'd3, 1'b1, 1'b1, 4'b1111, 32'h0);
    step();
    idle_ex();
    check("ill_no_req", {31'h0, bus.mem_req}, 32'h0);
    check("ill_fault", {31'h0, bus.mem_fault}, 32'h1);
    check("ill_no_wb", {31'h0, bus.wb_en}, 32'h0);
    check("ill_flags", {28'h0, bus.flags}, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the number of cycles mem_req may stay high without mem_ack before the access aborts.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports ex_valid  in  1 and ex_ready  out  1, which form the EX-to-MEM handshake.
REQ-005 SHALL have port ex_result  in  33  the EX result; bits [31:0] carry the data or address and bit 32 is ignored.
REQ-006 SHALL have port ex_dest_reg  in  3  the destination register index.
REQ-007 SHALL have port ex_wb_en  in  1  which requests a register writeback.
REQ-008 SHALL have ports ex_flags_en  in  1 and ex_flags_new  in  4, which carry the flag update in the order N,C,Z,V.
REQ-009 SHALL have ports ex_is_load  in  1, ex_is_store  in  1 and ex_store_data  in  32.
REQ-010 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  32 and mem_wdata  out  32.
REQ-011 SHALL have ports mem_ack  in  1 and mem_rdata  in  32.
REQ-012 SHALL have ports wb_en  out  1, wb_reg  out  3 and wb_data  out  32, which drive the register-file write port.
REQ-013 SHALL have port flags  out  4  the current CPSR, ordered N,C,Z,V.
REQ-014 SHALL have port mem_fault  out  1  a sticky error indicator.

Function
REQ-015 SHALL implement two states: IDLE and MEM_WAIT.
REQ-016 SHALL drive ex_ready=1 only in IDLE; a transfer occurs when ex_valid and ex_ready are both high at a clock edge.
REQ-017 SHALL, for a non-memory op with ex_wb_en=1, assert wb_en for exactly one cycle, the cycle after the transfer, with wb_reg=ex_dest_reg and wb_data=ex_result[31:0]; state stays IDLE, giving a throughput of one op per cycle.
REQ-018 SHALL, for a non-memory op with ex_flags_en=1, load flags from ex_flags_new on the transfer edge; flags are otherwise held.
REQ-019 SHALL, for a load or store, enter MEM_WAIT and raise mem_req on the transfer edge, with mem_addr=ex_result[31:0], mem_we=ex_is_store and mem_wdata=ex_store_data; these hold until the access completes.
REQ-020 SHALL sample mem_ack only while mem_req=1; on an acknowledged edge mem_req falls and state returns to IDLE.
REQ-021 SHALL, for a load acknowledged with ex_wb_en=1, pulse wb_en in the following cycle with wb_data=mem_rdata as sampled on the ack edge.
REQ-022 SHALL ignore ex_wb_en and ex_flags_en on stores, and ignore ex_flags_en on loads.
REQ-023 SHALL count MEM_WAIT cycles; when the count reaches MEM_TIMEOUT without ack it aborts: mem_req falls, no writeback occurs, mem_fault sets, and state returns to IDLE.
REQ-024 SHALL give ack priority when ack arrives on the same edge the count reaches MEM_TIMEOUT: the access completes normally and no fault is raised.
REQ-025 SHALL treat an access with ex_result[1:0]!=0 as misaligned: no mem_req is issued, mem_fault sets, there is no writeback, and state stays IDLE.
REQ-026 SHALL treat ex_is_load=1 together with ex_is_store=1 as illegal: the op is dropped, mem_fault sets, and there are no side effects.
REQ-027 SHALL keep mem_fault set until reset.
REQ-028 SHALL drive mem_we, mem_addr and mem_wdata to 0 whenever mem_req=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, all outputs to 0 (including ex_ready=0 during reset), flags=4'b0000 and the timeout counter to 0.
REQ-030 SHALL, on a reset mid-access, drop mem_req asynchronously, discard the pending writeback, and not re-issue the access.

Structure
REQ-031 SHALL take the state enum, the flag bit indices (N=3, C=2, Z=1, V=0) and the default timeout from the shared package cpu_pkg.
REQ-032 SHALL implement the CPSR flags register with load enable as one sub-module, cpsr_reg.

Verification
REQ-033 SHALL cover: non-memory op with ex_result=33'h0_0000_0005, dest=3, wb_en=1 and flags_en=1 with 4'b0010 -> next cycle wb_en=1, wb_reg=3, wb_data=5, flags=0010.
REQ-034 SHALL cover: load at address 0x100, with mem_ack 3 cycles after mem_req and mem_rdata=0xDEADBEEF -> ex_ready=0 during the wait, then a wb_en pulse with 0xDEADBEEF.
REQ-035 SHALL cover: store at 0x104 with data 0x12345678 -> mem_we=1, mem_wdata=0x12345678, and no wb_en.
REQ-036 SHALL cover: load with mem_ack never asserted -> mem_req falls after 16 cycles, mem_fault=1, no wb_en.
REQ-037 SHALL cover: load at address 0x102 -> mem_req never rises, mem_fault=1.
REQ-038 SHALL cover: rst_n low during MEM_WAIT -> mem_req=0 at once, no wb_en after reset release, flags=0000.
